alu_md: RTL and testbench
=========================

ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 Parameter XLEN, default 32, datapath width; SHALL be a power of two in 8..64.
REQ-002 Parameter M_EN, default 1, enables multiply/divide ops; when 0, m_ext SHALL be ignored and every op executes as a base op.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  request present; in_ready  output  1  block can accept.
REQ-006 in_a  input  XLEN  rs1 or PC; in_b  input  XLEN  rs2 or immediate.
REQ-007 func  input  3  operation select; alt  input  1  SUB/SRA select; m_ext  input  1  selects M-extension op.
REQ-008 flush  input  1  synchronous abort of any in-flight or held operation.
REQ-009 out_valid  output  1  result held; out_ready  input  1  consumer accepts; result  output  XLEN  result.

Function
REQ-010 Transfer in: in_valid && in_ready at a rising edge; transfer out: out_valid && out_ready at a rising edge.
REQ-011 States IDLE, BUSY, DONE; IDLE->DONE on base-op accept; IDLE->BUSY on M-op accept; BUSY->DONE when iteration count reaches XLEN+1; DONE->IDLE on output transfer without new accept.
REQ-012 in_ready SHALL be 1 in IDLE, and 1 in DONE only while out_ready is 1 (back-to-back issue); 0 in BUSY.
REQ-013 Base ops (m_ext=0): func 000 ADD/SUB(alt), 001 SLL, 010 SLT signed, 011 SLTU, 100 XOR, 101 SRL/SRA(alt), 110 OR, 111 AND; alt ignored for other codes.
REQ-014 Shift amount SHALL be in_b[log2(XLEN)-1:0] only; upper bits ignored.
REQ-015 SLT/SLTU result SHALL be zero-extended 0 or 1; ADD/SUB wrap modulo 2^XLEN.
REQ-016 Base-op latency: out_valid asserted in the cycle after the accepting edge.
REQ-017 M ops (m_ext=1): func 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU, RISC-V M semantics.
REQ-018 M-op latency: exactly XLEN iterative cycles plus one sign-fixup cycle; out_valid asserted XLEN+1 cycles after the accepting edge.
REQ-019 Divide by zero: DIV/DIVU result all ones; REM/REMU result = in_a.
REQ-020 Signed overflow (in_a = most-negative, in_b = -1): DIV result = in_a; REM result = 0.
REQ-021 Operands and op SHALL be captured at accept; input changes afterwards SHALL not affect result.
REQ-022 While out_valid=1 and out_ready=0, result SHALL remain stable and no new accept occurs.
REQ-023 flush=1 at an edge SHALL force IDLE, drop out_valid, discard result; flush wins over simultaneous in_valid (no accept that cycle).

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, out_valid 0, result 0, iteration counter 0; in_ready 1 after reset.
REQ-025 Reset mid-operation SHALL abandon the operation with no result produced after release.

Structure
REQ-026 Package alu_pkg SHALL hold the state enum, base and M func encodings, and the overflow/div-zero constants.
REQ-027 Iterative shift-add multiplier / restoring divider SHALL be sub-module alu_md_seq (start, operands, op, done, result); single-cycle base ops live in alu_md.

Verification (XLEN=32)
REQ-028 ADD 5,7 -> result 12, out_valid 1 cycle after accept; SUB 5,7 -> 0xFFFFFFFE.
REQ-029 SRA in_a=0x80000000, in_b=0x00000021 -> 0xC0000000; SLTU 1,0xFFFFFFFF -> 1; SLT same -> 0.
REQ-030 MUL -2,3 -> 0xFFFFFFFA; MULH -2,3 -> 0xFFFFFFFF; MULHU 0xFFFFFFFF,0xFFFFFFFF -> 0xFFFFFFFE; each out_valid exactly 33 cycles after accept.
REQ-031 DIV 7,0 -> 0xFFFFFFFF; REM 7,0 -> 7; DIV 0x80000000,0xFFFFFFFF -> 0x80000000; REM same -> 0; DIV -7,2 -> 0xFFFFFFFD; REM -7,2 -> 0xFFFFFFFF.
REQ-032 out_ready low 3 cycles after ADD result -> result stable, in_ready 0; then out_ready high with queued request -> accepted same edge, next result 1 cycle later.
REQ-033 DIV accepted, flush (or rst_n low) at iteration 10 -> out_valid never asserts, in_ready 1 next cycle, following ADD correct.

Source files
------------

// File: rtl/alu_md_pkg.sv
// Shared types and constants for the ALU with iterative multiply/divide.
// Operation encodings follow the RISC-V OP/OP-IMM and M-extension funct3 fields.
package alu_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;

  typedef enum logic [2:0] {
    F_ADD  = 3'b000,
    F_SLL  = 3'b001,
    F_SLT  = 3'b010,
    F_SLTU = 3'b011,
    F_XOR  = 3'b100,
    F_SR   = 3'b101,
    F_OR   = 3'b110,
    F_AND  = 3'b111
  } bfunc_e;

  typedef enum logic [2:0] {
    M_MUL    = 3'b000,
    M_MULH   = 3'b001,
    M_MULHSU = 3'b010,
    M_MULHU  = 3'b011,
    M_DIV    = 3'b100,
    M_DIVU   = 3'b101,
    M_REM    = 3'b110,
    M_REMU   = 3'b111
  } mfunc_e;

  // Wide constants, sliced to XLEN at the point of use.
  localparam logic [63:0] DIVZ_QUO = '1;
  localparam logic [63:0] OVF_REM  = '0;

endpackage

// File: rtl/alu_md_if.sv
// Request/response bundle between an issuing stage and alu_md.
interface alu_md_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic [2:0]      func;
  logic            alt;
  logic            m_ext;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, in_a, in_b, func, alt, m_ext, flush, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, in_a, in_b, func, alt, m_ext, flush, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/alu_md_seq.sv
// Iterative unit: shift-add multiplier and restoring divider on operand magnitudes,
// XLEN step cycles followed by one sign/special-case fixup cycle.
module alu_md_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            abort,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  mfunc_e          op,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN + 2);
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

  logic              busy;
  logic [CW-1:0]     cnt;
  mfunc_e            op_q;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   dvs, a_q, madd_op, quo, rem;
  logic              a_neg, b_neg, a_sgn, b_sgn, divz, ovf;
  logic [XLEN:0]     madd, trial, dsub;
  logic [2*XLEN-1:0] prod_s;

  assign a_sgn = (op inside {M_MULH, M_MULHSU, M_DIV, M_REM}) && a[XLEN-1];
  assign b_sgn = (op inside {M_MULH, M_DIV, M_REM}) && b[XLEN-1];

  // acc holds {partial product | remainder, multiplier | dividend->quotient}.
  assign madd_op = acc[0] ? dvs : {XLEN{1'b0}};
  assign madd    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, madd_op};
  assign trial   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign dsub    = trial - {1'b0, dvs};

  assign done = busy && (cnt == CW'(XLEN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      cnt   <= '0;
      op_q  <= M_MUL;
      acc   <= '0;
      dvs   <= '0;
      a_q   <= '0;
      a_neg <= 1'b0;
      b_neg <= 1'b0;
    end else if (abort) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      op_q  <= op;
      a_q   <= a;
      a_neg <= a_sgn;
      b_neg <= b_sgn;
      dvs   <= b_sgn ? -b : b;
      acc   <= {{XLEN{1'b0}}, (a_sgn ? -a : a)};
    end else if (busy) begin
      cnt <= cnt + CW'(1);
      if (cnt == CW'(XLEN)) begin
        busy <= 1'b0;
      end else if (op_q[2]) begin
        acc <= dsub[XLEN] ? {trial[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                          : {dsub[XLEN-1:0],  acc[XLEN-2:0], 1'b1};
      end else begin
        acc <= {madd, acc[XLEN-1:1]};
      end
    end
  end

  // Fixup: restore signs and apply the divide-by-zero / overflow results.
  always_comb begin
    prod_s = (a_neg ^ b_neg) ? -acc : acc;
    quo    = acc[XLEN-1:0];
    rem    = acc[2*XLEN-1:XLEN];
    divz   = (dvs == '0);
    ovf    = a_neg && b_neg && (dvs == XLEN'(1)) && (a_q == MINV);
    result = '0;
    unique case (op_q)
      M_MUL:                     result = prod_s[XLEN-1:0];
      M_MULH, M_MULHSU, M_MULHU: result = prod_s[2*XLEN-1:XLEN];
      M_DIV, M_DIVU: begin
        if (divz)     result = DIVZ_QUO[XLEN-1:0];
        else if (ovf) result = a_q;
        else          result = (a_neg ^ b_neg) ? -quo : quo;
      end
      M_REM, M_REMU: begin
        if (divz)     result = a_q;
        else if (ovf) result = OVF_REM[XLEN-1:0];
        else          result = a_neg ? -rem : rem;
      end
      default:       result = '0;
    endcase
  end

endmodule

// File: rtl/alu_md.sv
// Integer ALU: single-cycle base ops plus iterative M-extension ops behind a
// valid/ready handshake with a one-entry result register.
module alu_md
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int M_EN = 1
) (
  input logic     clk,
  input logic     rst_n,
  alu_md_if.slave bus
);
  localparam int SW = $clog2(XLEN);

  state_e          state;
  logic            accept, m_op, seq_done, out_valid_q;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] base_res, sra_res, seq_res, result_q;

  assign m_op   = (M_EN != 0) && bus.m_ext;
  // Ready in DONE only when the held result leaves on the same edge.
  assign bus.in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready && !bus.flush;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

  assign shamt   = bus.in_b[SW-1:0];
  assign sra_res = $signed(bus.in_a) >>> shamt;

  always_comb begin
    base_res = '0;
    unique case (bfunc_e'(bus.func))
      F_ADD:  base_res = bus.alt ? (bus.in_a - bus.in_b) : (bus.in_a + bus.in_b);
      F_SLL:  base_res = bus.in_a << shamt;
      F_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(bus.in_a) < $signed(bus.in_b))};
      F_SLTU: base_res = {{(XLEN-1){1'b0}}, (bus.in_a < bus.in_b)};
      F_XOR:  base_res = bus.in_a ^ bus.in_b;
      F_SR:   base_res = bus.alt ? sra_res : (bus.in_a >> shamt);
      F_OR:   base_res = bus.in_a | bus.in_b;
      F_AND:  base_res = bus.in_a & bus.in_b;
      default: base_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else if (bus.flush) begin
      state       <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (m_op) begin
              state       <= ST_BUSY;
              out_valid_q <= 1'b0;
            end else begin
              state       <= ST_DONE;
              out_valid_q <= 1'b1;
              result_q    <= base_res;
            end
          end else if ((state == ST_DONE) && bus.out_ready) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (seq_done) begin
            state       <= ST_DONE;
            out_valid_q <= 1'b1;
            result_q    <= seq_res;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  alu_md_seq #(.XLEN(XLEN)) u_seq (
    .clk    (clk),
    .rst_n  (rst_n),
    .abort  (bus.flush),
    .start  (accept && m_op),
    .a      (bus.in_a),
    .b      (bus.in_b),
    .op     (mfunc_e'(bus.func)),
    .done   (seq_done),
    .result (seq_res)
  );

endmodule

// File: tb/tb_alu_md.sv
// Randomized + directed bench for alu_md (XLEN=32) against an arithmetic reference model.
module tb_alu_md;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_md_if #(.XLEN(32)) bus();
  alu_md #(.XLEN(32), .M_EN(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V semantics with plain 32/64-bit integer arithmetic.
  function automatic logic [31:0] model(bit m, bit [2:0] f, bit alt, logic [31:0] a, logic [31:0] b);
    int sa, sb, r;
    longint p;
    longint unsigned pu;
    sa = a;
    sb = b;
    if (!m) begin
      case (f)
        3'd0: return alt ? a - b : a + b;
        3'd1: return a << b[4:0];
        3'd2: return (sa < sb) ? 32'd1 : 32'd0;
        3'd3: return (a < b) ? 32'd1 : 32'd0;
        3'd4: return a ^ b;
        3'd5: begin
          if (alt) begin r = sa >>> b[4:0]; return r; end
          return a >> b[4:0];
        end
        3'd6: return a | b;
        default: return a & b;
      endcase
    end
    case (f)
      3'd0: return a * b;
      3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        r = sa / sb; return r;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        r = sa % sb; return r;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic drive(bit m, bit [2:0] f, bit alt, logic [31:0] a, logic [31:0] b);
    bus.m_ext = m; bus.func = f; bus.alt = alt;
    bus.in_a = a;  bus.in_b = b; bus.in_valid = 1'b1;
  endtask

  // One transaction: accept, scramble inputs, time the result, let it drain.
  task automatic run_op(input string tag, input bit m, input bit [2:0] f, input bit alt,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int lat, w;
    @(negedge clk);
    drive(m, f, alt, a, b);
    w = 0;
    while (!bus.in_ready && w < 100) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_a = $urandom; bus.in_b = $urandom; bus.alt = 1'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    // base ops are registered on the accepting edge; M ops take XLEN+1 more edges
    chk({tag, ".lat"}, lat, m ? 33 : 0);
    chk(tag, bus.result, exp);
    @(posedge clk); #1;
  endtask

  task automatic abort_test(input bit use_rst);
    int seen;
    string t;
    t = use_rst ? "rst" : "flush";
    @(negedge clk);
    drive(1'b1, 3'd4, 1'b0, 32'd100, 32'd7);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    if (use_rst) begin
      #1 rst_n = 1'b0;
      #1;
      chk({t, ".ov"},  bus.out_valid, 0);
      chk({t, ".res"}, bus.result, 0);
      chk({t, ".rdy"}, bus.in_ready, 1);
      @(negedge clk); rst_n = 1'b1;
    end else begin
      @(negedge clk); bus.flush = 1'b1;
      @(posedge clk); #1; bus.flush = 1'b0;
      chk({t, ".ov"},  bus.out_valid, 0);
      chk({t, ".rdy"}, bus.in_ready, 1);
    end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.out_valid) seen++; end
    chk({t, ".none"}, seen, 0);
    run_op({t, ".add"}, 1'b0, 3'd0, 1'b0, 32'd3, 32'd4, 32'd7);
  endtask

  logic [31:0] corner [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bit m, alt;
    bit [2:0] f;
    logic [31:0] a, b;
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    bus.in_a = '0; bus.in_b = '0; bus.func = '0; bus.alt = 1'b0; bus.m_ext = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.ov",  bus.out_valid, 0);
    chk("reset.res", bus.result, 0);
    chk("reset.rdy", bus.in_ready, 1);
    @(negedge clk); rst_n = 1'b1;

    run_op("add",    0, 3'd0, 0, 32'd5, 32'd7, 32'd12);
    run_op("sub",    0, 3'd0, 1, 32'd5, 32'd7, 32'hFFFF_FFFE);
    run_op("sra",    0, 3'd5, 1, 32'h8000_0000, 32'h21, 32'hC000_0000);
    run_op("srl",    0, 3'd5, 0, 32'h8000_0000, 32'h21, 32'h4000_0000);
    run_op("sltu",   0, 3'd3, 0, 32'd1, 32'hFFFF_FFFF, 32'd1);
    run_op("slt",    0, 3'd2, 0, 32'd1, 32'hFFFF_FFFF, 32'd0);
    run_op("mul",    1, 3'd0, 0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA);
    run_op("mulh",   1, 3'd1, 0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);
    run_op("mulhu",  1, 3'd3, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("div0",   1, 3'd4, 0, 32'd7, 32'd0, 32'hFFFF_FFFF);
    run_op("rem0",   1, 3'd6, 0, 32'd7, 32'd0, 32'd7);
    run_op("divovf", 1, 3'd4, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("removf", 1, 3'd6, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_op("divneg", 1, 3'd4, 0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op("remneg", 1, 3'd6, 0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);

    // Backpressure with a queued request behind the held result.
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(0, 3'd0, 0, 32'd5, 32'd7);
    @(posedge clk); #1;
    drive(0, 3'd0, 0, 32'd10, 32'd20);
    chk("bp.ov",  bus.out_valid, 1);
    chk("bp.res", bus.result, 12);
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp.hold", bus.result, 12);
      chk("bp.rdy",  bus.in_ready, 0);
      chk("bp.ovh",  bus.out_valid, 1);
    end
    @(negedge clk); bus.out_ready = 1'b1; #1;
    chk("bp.rdy1", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp.next.ov", bus.out_valid, 1);
    chk("bp.next",    bus.result, 30);
    @(posedge clk); #1;
    chk("bp.drain", bus.out_valid, 0);

    // Flush beats a simultaneous request.
    @(negedge clk);
    drive(0, 3'd0, 0, 32'd1, 32'd1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("flacc.ov",  bus.out_valid, 0);
    chk("flacc.rdy", bus.in_ready, 1);
    @(posedge clk); #1;
    chk("flacc.ov2", bus.out_valid, 0);

    abort_test(1'b0);
    abort_test(1'b1);

    for (int i = 0; i < 60; i++) begin
      m = 1'($urandom); f = 3'($urandom); alt = 1'($urandom);
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 32'($urandom);
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 32'($urandom);
      if ($urandom_range(0, 4) == 0) b = 32'($urandom_range(0, 40));
      run_op($sformatf("rnd%0d.m%0d.f%0d.a%0d", i, m, f, alt), m, f, alt, a, b, model(m, f, alt, a, b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
